// File: rtl/ysyx_041514_csr_regfile.sv
// Machine-mode CSR register file: commit, read mux, trap/mret, counters
// and interrupt pending evaluation.
module ysyx_041514_csr_regfile #(
   parameter int unsigned     XLEN         = 64,
   parameter int unsigned     CSR_ADDR_LEN = 12,
   parameter logic [XLEN-1:0] MTVEC_RESET  = 64'h0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CSR_ADDR_LEN-1:0] csr_raddr_i,
   output logic [XLEN-1:0]         csr_rdata_o,
   output logic                    csr_rillegal_o,
   input  logic                    csr_wen_i,
   input  logic [CSR_ADDR_LEN-1:0] csr_waddr_i,
   input  logic [XLEN-1:0]         csr_wdata_i,
   input  logic                    retire_i,
   input  logic                    trap_valid_i,
   input  logic [XLEN-1:0]         trap_cause_i,
   input  logic [XLEN-1:0]         trap_pc_i,
   input  logic                    mret_valid_i,
   input  logic                    timer_irq_i,
   input  logic                    ext_irq_i,
   output logic [XLEN-1:0]         mtvec_o,
   output logic [XLEN-1:0]         mepc_o,
   output logic                    irq_pending_o
);

   localparam logic [CSR_ADDR_LEN-1:0] A_MSTATUS  = CSR_ADDR_LEN'(12'h300);
   localparam logic [CSR_ADDR_LEN-1:0] A_MIE      = CSR_ADDR_LEN'(12'h304);
   localparam logic [CSR_ADDR_LEN-1:0] A_MTVEC    = CSR_ADDR_LEN'(12'h305);
   localparam logic [CSR_ADDR_LEN-1:0] A_MSCRATCH = CSR_ADDR_LEN'(12'h340);
   localparam logic [CSR_ADDR_LEN-1:0] A_MEPC     = CSR_ADDR_LEN'(12'h341);
   localparam logic [CSR_ADDR_LEN-1:0] A_MCAUSE   = CSR_ADDR_LEN'(12'h342);
   localparam logic [CSR_ADDR_LEN-1:0] A_MIP      = CSR_ADDR_LEN'(12'h344);
   localparam logic [CSR_ADDR_LEN-1:0] A_MCYCLE   = CSR_ADDR_LEN'(12'hB00);
   localparam logic [CSR_ADDR_LEN-1:0] A_MINSTRET = CSR_ADDR_LEN'(12'hB02);
   localparam logic [CSR_ADDR_LEN-1:0] A_MHARTID  = CSR_ADDR_LEN'(12'hF14);

   // Clears the two low bits of pc-like values (direct mode, IALIGN=32).
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   logic            mie_q, mie_d;
   logic            mpie_q, mpie_d;
   logic            meie_q, meie_d;
   logic            mtie_q, mtie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [XLEN-1:0] mcycle_q, mcycle_d;
   logic [XLEN-1:0] minstret_q, minstret_d;

   logic            wr_mstatus, wr_mie, wr_mtvec, wr_mscratch;
   logic            wr_mepc, wr_mcause, wr_mcycle, wr_minstret;
   logic [XLEN-1:0] mstatus_rd, mie_rd, mip_rd;

   assign wr_mstatus  = csr_wen_i && (csr_waddr_i == A_MSTATUS);
   assign wr_mie      = csr_wen_i && (csr_waddr_i == A_MIE);
   assign wr_mtvec    = csr_wen_i && (csr_waddr_i == A_MTVEC);
   assign wr_mscratch = csr_wen_i && (csr_waddr_i == A_MSCRATCH);
   assign wr_mepc     = csr_wen_i && (csr_waddr_i == A_MEPC);
   assign wr_mcause   = csr_wen_i && (csr_waddr_i == A_MCAUSE);
   assign wr_mcycle   = csr_wen_i && (csr_waddr_i == A_MCYCLE);
   assign wr_minstret = csr_wen_i && (csr_waddr_i == A_MINSTRET);

   // MPP is hardwired to machine mode, so only MIE/MPIE are stored.
   assign mstatus_rd = {{(XLEN-13){1'b0}}, 2'b11, 3'b0, mpie_q,
                        3'b0, mie_q, 3'b0};
   assign mie_rd     = {{(XLEN-12){1'b0}}, meie_q, 3'b0, mtie_q, 7'b0};
   assign mip_rd     = {{(XLEN-12){1'b0}}, ext_irq_i, 3'b0,
                        timer_irq_i, 7'b0};

   assign mtvec_o       = mtvec_q;
   assign mepc_o        = mepc_q;
   assign irq_pending_o = mie_q & ((meie_q & ext_irq_i) |
                                   (mtie_q & timer_irq_i));

   // Next state: trap beats mret beats a CSR write on mstatus/mepc/mcause.
   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      meie_d     = meie_q;
      mtie_d     = mtie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      if (trap_valid_i) begin
         mpie_d   = mie_q;
         mie_d    = 1'b0;
         mepc_d   = trap_pc_i & ALIGN_MASK;
         mcause_d = trap_cause_i;
      end else if (mret_valid_i) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end else begin
         if (wr_mstatus) begin
            mie_d  = csr_wdata_i[3];
            mpie_d = csr_wdata_i[7];
         end
         if (wr_mepc)   mepc_d   = csr_wdata_i & ALIGN_MASK;
         if (wr_mcause) mcause_d = csr_wdata_i;
      end
      if (wr_mie) begin
         meie_d = csr_wdata_i[11];
         mtie_d = csr_wdata_i[7];
      end
      if (wr_mtvec)    mtvec_d    = csr_wdata_i & ALIGN_MASK;
      if (wr_mscratch) mscratch_d = csr_wdata_i;
      mcycle_d   = wr_mcycle ? csr_wdata_i : mcycle_q + XLEN'(1);
      minstret_d = wr_minstret ? csr_wdata_i
                 : minstret_q + XLEN'(retire_i);
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         meie_q     <= 1'b0;
         mtie_q     <= 1'b0;
         mtvec_q    <= MTVEC_RESET & ALIGN_MASK;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         meie_q     <= meie_d;
         mtie_q     <= mtie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end

   // Zero-latency read mux; unknown addresses read 0 and flag illegal.
   always_comb begin
      csr_rdata_o    = '0;
      csr_rillegal_o = 1'b0;
      case (csr_raddr_i)
         A_MSTATUS:  csr_rdata_o = mstatus_rd;
         A_MIE:      csr_rdata_o = mie_rd;
         A_MTVEC:    csr_rdata_o = mtvec_q;
         A_MSCRATCH: csr_rdata_o = mscratch_q;
         A_MEPC:     csr_rdata_o = mepc_q;
         A_MCAUSE:   csr_rdata_o = mcause_q;
         A_MIP:      csr_rdata_o = mip_rd;
         A_MCYCLE:   csr_rdata_o = mcycle_q;
         A_MINSTRET: csr_rdata_o = minstret_q;
         A_MHARTID:  csr_rdata_o = '0;
         default:    csr_rillegal_o = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_ysyx_041514_csr_regfile.sv
// Bench for ysyx_041514_csr_regfile: directed checks followed by random
// traffic compared against a full-width behavioural CSR model.
module tb_ysyx_041514_csr_regfile;

   localparam logic [63:0] MTVEC_RESET = 64'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] csr_raddr_i = '0;
   logic [63:0] csr_rdata_o;
   logic        csr_rillegal_o;
   logic        csr_wen_i = 1'b0;
   logic [11:0] csr_waddr_i = '0;
   logic [63:0] csr_wdata_i = '0;
   logic        retire_i = 1'b0;
   logic        trap_valid_i = 1'b0;
   logic [63:0] trap_cause_i = '0;
   logic [63:0] trap_pc_i = '0;
   logic        mret_valid_i = 1'b0;
   logic        timer_irq_i = 1'b0;
   logic        ext_irq_i = 1'b0;
   logic [63:0] mtvec_o;
   logic [63:0] mepc_o;
   logic        irq_pending_o;

   int nvec = 0;
   int nerr = 0;

   ysyx_041514_csr_regfile #(
      .XLEN(64), .CSR_ADDR_LEN(12), .MTVEC_RESET(MTVEC_RESET)
   ) dut (
      .clk(clk), .rst(rst),
      .csr_raddr_i(csr_raddr_i), .csr_rdata_o(csr_rdata_o),
      .csr_rillegal_o(csr_rillegal_o),
      .csr_wen_i(csr_wen_i), .csr_waddr_i(csr_waddr_i),
      .csr_wdata_i(csr_wdata_i), .retire_i(retire_i),
      .trap_valid_i(trap_valid_i), .trap_cause_i(trap_cause_i),
      .trap_pc_i(trap_pc_i), .mret_valid_i(mret_valid_i),
      .timer_irq_i(timer_irq_i), .ext_irq_i(ext_irq_i),
      .mtvec_o(mtvec_o), .mepc_o(mepc_o), .irq_pending_o(irq_pending_o)
   );

   always #10 clk = ~clk;

   // Reference model: architectural CSR values held at full width.
   logic [63:0] m_status, m_ie, m_tvec, m_scratch;
   logic [63:0] m_epc, m_cause, m_cycle, m_instret;

   // Model update on each clock edge, or immediately on reset.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_status  <= 64'h1800;
         m_ie      <= '0;
         m_tvec    <= MTVEC_RESET & ~64'h3;
         m_scratch <= '0;
         m_epc     <= '0;
         m_cause   <= '0;
         m_cycle   <= '0;
         m_instret <= '0;
      end else begin
         if (csr_wen_i && csr_waddr_i == 12'hB00) m_cycle <= csr_wdata_i;
         else m_cycle <= m_cycle + 64'd1;
         if (csr_wen_i && csr_waddr_i == 12'hB02) m_instret <= csr_wdata_i;
         else if (retire_i) m_instret <= m_instret + 64'd1;
         if (csr_wen_i && csr_waddr_i == 12'h304)
            m_ie <= csr_wdata_i & 64'h880;
         if (csr_wen_i && csr_waddr_i == 12'h305)
            m_tvec <= csr_wdata_i & ~64'h3;
         if (csr_wen_i && csr_waddr_i == 12'h340) m_scratch <= csr_wdata_i;
         if (trap_valid_i) begin
            m_epc    <= trap_pc_i & ~64'h3;
            m_cause  <= trap_cause_i;
            m_status <= 64'h1800 | ((m_status & 64'h8) << 4);
         end else if (mret_valid_i) begin
            m_status <= 64'h1880 | ((m_status >> 4) & 64'h8);
         end else begin
            if (csr_wen_i && csr_waddr_i == 12'h300)
               m_status <= 64'h1800 | (csr_wdata_i & 64'h88);
            if (csr_wen_i && csr_waddr_i == 12'h341)
               m_epc <= csr_wdata_i & ~64'h3;
            if (csr_wen_i && csr_waddr_i == 12'h342)
               m_cause <= csr_wdata_i;
         end
      end
   end

   function automatic logic [64:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return {1'b0, m_status};
         12'h304: return {1'b0, m_ie};
         12'h305: return {1'b0, m_tvec};
         12'h340: return {1'b0, m_scratch};
         12'h341: return {1'b0, m_epc};
         12'h342: return {1'b0, m_cause};
         12'h344: return {1'b0, 52'b0, ext_irq_i, 3'b0, timer_irq_i, 7'b0};
         12'hB00: return {1'b0, m_cycle};
         12'hB02: return {1'b0, m_instret};
         12'hF14: return {1'b0, 64'h0};
         default: return {1'b1, 64'h0};
      endcase
   endfunction

   function automatic logic m_irq();
      logic [63:0] mip;
      mip = {52'b0, ext_irq_i, 3'b0, timer_irq_i, 7'b0};
      return m_status[3] && ((m_ie & mip) != 0);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd_const(input logic [11:0] a, input logic [63:0] exp);
      csr_raddr_i = a;
      #1;
      chk($sformatf("rd_%h", a), csr_rdata_o, exp);
   endtask

   task automatic rd_model(input logic [11:0] a);
      logic [64:0] r;
      csr_raddr_i = a;
      #1;
      r = m_read(a);
      chk($sformatf("rd_%h", a), csr_rdata_o, r[63:0]);
      chk($sformatf("ill_%h", a), {63'b0, csr_rillegal_o}, {63'b0, r[64]});
   endtask

   task automatic out_model();
      chk("mtvec_o", mtvec_o, m_tvec);
      chk("mepc_o", mepc_o, m_epc);
      chk("irq_pending", {63'b0, irq_pending_o}, {63'b0, m_irq()});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      csr_wen_i    = 1'b0;
      trap_valid_i = 1'b0;
      mret_valid_i = 1'b0;
      retire_i     = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [63:0] d);
      csr_wen_i   = 1'b1;
      csr_waddr_i = a;
      csr_wdata_i = d;
   endtask

   logic [11:0] addrs [11] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                               12'h342, 12'h344, 12'hB00, 12'hB02, 12'hF14,
                               12'h7C0};

   task automatic rand_cycle();
      wr(addrs[$urandom_range(10)], {$urandom, $urandom});
      if ($urandom_range(3) == 0) csr_wdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
      csr_wen_i    = ($urandom_range(1) == 1);
      retire_i     = ($urandom_range(1) == 1);
      trap_valid_i = ($urandom_range(5) == 0);
      mret_valid_i = ($urandom_range(5) == 0);
      trap_cause_i = {$urandom, $urandom};
      trap_pc_i    = {$urandom, $urandom};
      timer_irq_i  = ($urandom_range(1) == 1);
      ext_irq_i    = ($urandom_range(1) == 1);
      if (mret_valid_i && !trap_valid_i &&
          (csr_waddr_i == 12'h341 || csr_waddr_i == 12'h342))
         csr_wen_i = 1'b0;
      tick();
      for (int i = 0; i < 11; i++) rd_model(addrs[i]);
      out_model();
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      rd_const(12'h300, 64'h1800);
      rd_const(12'h305, MTVEC_RESET);
      rd_const(12'h7C0, 64'h0);
      chk("rst_ill", {63'b0, csr_rillegal_o}, 64'd1);
      chk("rst_mtvec_o", mtvec_o, MTVEC_RESET & ~64'h3);
      chk("rst_mepc_o", mepc_o, 64'h0);
      chk("rst_irq", {63'b0, irq_pending_o}, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      wr(12'h300, '1); tick();
      rd_const(12'h300, 64'h1888);
      wr(12'h305, 64'h8000_0007); tick();
      rd_const(12'h305, 64'h8000_0004);
      chk("mtvec_o", mtvec_o, 64'h8000_0004);
      wr(12'h344, '1); tick();
      rd_const(12'h344, 64'h0);

      trap_valid_i = 1'b1; trap_pc_i = 64'h8000_0102; trap_cause_i = 64'd11;
      tick();
      rd_const(12'h341, 64'h8000_0100);
      rd_const(12'h342, 64'd11);
      rd_const(12'h300, 64'h1880);
      chk("mepc_o", mepc_o, 64'h8000_0100);
      mret_valid_i = 1'b1; tick();
      rd_const(12'h300, 64'h1888);

      wr(12'h341, 64'd5);
      trap_valid_i = 1'b1; trap_pc_i = 64'h8000_0204; tick();
      rd_const(12'h341, 64'h8000_0204);
      wr(12'h340, 64'd5);
      trap_valid_i = 1'b1; trap_pc_i = 64'h8000_0300; tick();
      rd_const(12'h340, 64'd5);

      wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE); tick();
      rd_const(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
      tick();
      rd_const(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      rd_const(12'hB00, 64'h0);

      wr(12'hB02, 64'd100); retire_i = 1'b1; tick();
      rd_const(12'hB02, 64'd100);
      retire_i = 1'b1; tick();
      tick();
      retire_i = 1'b1; tick();
      retire_i = 1'b1; tick();
      tick();
      rd_const(12'hB02, 64'd103);

      wr(12'h304, 64'h80); tick();
      wr(12'h300, 64'h8); tick();
      timer_irq_i = 1'b1; #1;
      chk("irq_on", {63'b0, irq_pending_o}, 64'd1);
      wr(12'h300, 64'h0); tick();
      chk("irq_mie0", {63'b0, irq_pending_o}, 64'd0);
      wr(12'h300, 64'h8); timer_irq_i = 1'b0; ext_irq_i = 1'b1; tick();
      chk("irq_ext_masked", {63'b0, irq_pending_o}, 64'd0);
      rd_model(12'h344);

      for (int n = 0; n < 300; n++) rand_cycle();

      @(posedge clk);
      #5 rst = 1'b1;
      #1;
      chk("arst_mtvec_o", mtvec_o, MTVEC_RESET & ~64'h3);
      chk("arst_mepc_o", mepc_o, 64'h0);
      chk("arst_irq", {63'b0, irq_pending_o}, 64'd0);
      rd_const(12'h300, 64'h1800);
      rd_const(12'hB00, 64'h0);
      rd_const(12'h340, 64'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int n = 0; n < 40; n++) rand_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/ysyx_041514_csr_regfile.md
Name: ysyx_041514_csr_regfile

Overview:
Machine-mode CSR register file at the write-back end of the CSR datapath. It takes the new CSR value produced in execute and commits it. It also serves the combinational CSR read that feeds execute. Trap entry, mret, the cycle and instret counters, and interrupt pending/enable evaluation all live here, and the block drives the redirect targets mtvec and mepc to the fetch stage.

Parameters:
XLEN, 64, data width of every CSR
CSR_ADDR_LEN, 12, CSR address width
MTVEC_RESET, 64'h0, reset value of mtvec

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
csr_raddr_i  input  CSR_ADDR_LEN  read address
csr_rdata_o  output  XLEN  read data, combinational, current register value (no write bypass)
csr_rillegal_o  output  1  read address not implemented
csr_wen_i  input  1  commit a CSR write this cycle (execute data-valid after pipeline)
csr_waddr_i  input  CSR_ADDR_LEN  write address
csr_wdata_i  input  XLEN  value to commit
retire_i  input  1  one instruction retires this cycle
trap_valid_i  input  1  take trap this cycle
trap_cause_i  input  XLEN  mcause value (bit XLEN-1 set = interrupt)
trap_pc_i  input  XLEN  pc of trapping instruction
mret_valid_i  input  1  mret commits this cycle
timer_irq_i  input  1  level, reflected in mip.MTIP
ext_irq_i  input  1  level, reflected in mip.MEIP
mtvec_o  output  XLEN  trap target (mtvec with bits [1:0] cleared)
mepc_o  output  XLEN  mret target
irq_pending_o  output  1  mstatus.MIE & |(mie & mip) over bits 7,11

Behaviour:
- Implemented CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, minstret 0xB02, mhartid 0xF14.
- Reset values: all registers 0, except mtvec=MTVEC_RESET and mstatus.MPP=2'b11.
- Reset output values: csr_rdata_o is the register selected by csr_raddr_i; mtvec_o=MTVEC_RESET with [1:0] cleared; mepc_o=0; irq_pending_o=0.
- Read: csr_rdata_o is the register selected by csr_raddr_i, zero-latency.
  - Unimplemented address: csr_rdata_o=0 and csr_rillegal_o=1.
  - mip reads {.., MEIP[11]=ext_irq_i, .., MTIP[7]=timer_irq_i}, all other bits 0.
  - mhartid reads 0.
- Write masks, applied on the edge when csr_wen_i=1:
  - mstatus: only MIE[3] and MPIE[7] writable; MPP[12:11] hardwired 11; other bits read 0.
  - mie: only bits 7 and 11 writable.
  - mtvec: bits [XLEN-1:2] writable, [1:0] read 0 (direct mode only).
  - mepc: bits [1:0] forced 0.
  - mscratch, mcause, mcycle, minstret: full width.
  - mip, mhartid, and unimplemented addresses: write silently ignored.
- Counters:
  - mcycle += 1 every cycle.
  - minstret += 1 when retire_i=1.
  - Both wrap 2^XLEN-1 -> 0.
  - A CSR write to a counter in the same cycle wins: the register takes wdata exactly, with no increment that cycle; incrementing resumes next cycle.
- Trap entry (trap_valid_i=1), on the edge:
  - mepc <= trap_pc_i & ~3
  - mcause <= trap_cause_i
  - MPIE <= MIE
  - MIE <= 0
  - MPP <= 11
- mret (mret_valid_i=1): MIE <= MPIE, MPIE <= 1.
- Priority within one cycle: trap > mret > csr write for mstatus/mepc/mcause.
  - A lower-priority update to those registers is dropped.
  - A csr write to any other register still commits alongside the trap or mret.
  - Counter increments are unaffected by trap or mret.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). First update happens on the first rising edge after rst deasserts.
- mtvec_o and mepc_o are registered values, visible the cycle after the write commits.

Test Plan:
- Reset and read: assert rst, then read 0x300 -> 64'h1800; read 0x305 -> MTVEC_RESET; read 0x7C0 -> rdata 0, rillegal 1.
- Write masks:
  - write 0x300 = all-ones -> reads 64'h1888.
  - write 0x305 = 64'h8000_0007 -> reads and mtvec_o 64'h8000_0004.
  - write 0x344 = all-ones -> mip unchanged.
- Trap then mret:
  - Set MIE=1, then trap_pc_i=64'h8000_0102, cause=11 -> mepc 64'h8000_0100, mcause 11, mstatus 64'h1880.
  - Then mret -> mstatus 64'h1888.
- Simultaneous events:
  - trap together with csr write 0x341 = 5 -> mepc holds trap pc.
  - trap together with write 0x340 = 5 -> mscratch = 5.
- Counters:
  - write mcycle = 64'hFFFF_FFFF_FFFF_FFFE -> reads ...FFFE, next cycle ...FFFF, next 0.
  - retire_i asserted in 3 of 5 cycles -> minstret advances by 3.
  - write minstret while retire_i=1 -> exact wdata.
- Interrupts:
  - mie=64'h80, MIE=1, timer_irq_i=1 -> irq_pending_o=1.
  - Clear MIE -> irq_pending_o=0.
  - ext_irq_i=1 with mie bit 11=0 -> irq_pending_o=0.
- Async reset mid-run: assert rst between edges -> outputs at reset values immediately.
